mack_bus_ctrl: RTL and testbench

- Parametrised 68000 bus controller for the Mackerel board.
- Decodes upper address bits into ROM, MFP and RAM chip selects, with a boot-time ROM overlay held for a programmable number of bus cycles.
- Generates DTACK internally with per-region wait states, and passes external DTACK through for the MFP and for IACK cycles.
- Asserts BERR on unmapped or hung cycles after a timeout, and provides a divided clock for slow peripherals.

---
 rtl/mack_bus_pkg.sv | 38 +++
 rtl/mack_boot_overlay.sv | 48 ++++
 rtl/mack_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mack_bus_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mack_bus_pkg.sv
`default_nettype none
// Shared types for the Mackerel 68000 bus controller: decode regions, FSM states
// and the A21..A19 codes that select each region.
package mack_bus_pkg;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_MFP  = 2'd2,
    REG_RAM  = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_EXT  = 3'd2,
    ST_TOUT = 3'd3,
    ST_ACK  = 3'd4,
    ST_BERR = 3'd5
  } state_e;

  localparam logic [2:0] CODE_ROM = 3'b111;
  localparam logic [2:0] CODE_MFP = 3'b110;
  localparam logic [2:0] CODE_RAM = 3'b000;

  function automatic region_e decode_region(input logic [2:0] code);
    region_e r;
    case (code)
      CODE_ROM: r = REG_ROM;
      CODE_MFP: r = REG_MFP;
      CODE_RAM: r = REG_RAM;
      default:  r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mack_boot_overlay.sv
`default_nettype none
// Boot overlay tracker: counts AS falling edges until BOOT_CYCLES have completed,
// then raises BOOT on the next AS-high sample and holds it until reset.
module mack_boot_overlay
  import mack_bus_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS,
  output logic BOOT
);

  localparam logic [7:0] BOOT_LIMIT = 8'(BOOT_CYCLES);

  logic [7:0] count_q, count_d;
  logic       boot_q, boot_d;
  logic       as_prev_q;

  always_comb begin
    count_d = count_q;
    boot_d  = boot_q;
    // as_prev_q resets low, so an AS still held low across reset is not counted
    if (!boot_q && as_prev_q && !AS && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
    if (AS && (count_q >= BOOT_LIMIT)) begin
      boot_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_q   <= 8'd0;
      boot_q    <= 1'b0;
      as_prev_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      boot_q    <= boot_d;
      as_prev_q <= AS;
    end
  end

  assign BOOT = boot_q;

endmodule
`default_nettype wire

// File: rtl/mack_bus_ctrl.sv
`default_nettype none
// Mackerel 68000 bus controller: chip-select decode with boot ROM overlay,
// internal/external DTACK generation, BERR timeout and a divided slow clock.
module mack_bus_ctrl
  import mack_bus_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 8,
  parameter int unsigned ROM_WS       = 2,
  parameter int unsigned RAM_WS       = 0,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter int unsigned CLK_DIV_LOG2 = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] ADDR,
  input  logic       AS,
  input  logic       IACK,
  input  logic       DTACK_IN,
  output logic       CLK_SLOW,
  output logic       ROMEN,
  output logic       MFPEN,
  output logic       RAMEN,
  output logic       DTACK,
  output logic       BERR,
  output logic       BOOT
);

  localparam logic [3:0] ROM_WAIT  = 4'(ROM_WS);
  localparam logic [3:0] RAM_WAIT  = 4'(RAM_WS);
  localparam logic [9:0] TOUT_LAST = 10'(BERR_TIMEOUT - 1);

  logic [CLK_DIV_LOG2-1:0] div_q, div_d;
  state_e                  state_q, state_d;
  region_e                 region_q, region_d;
  logic [3:0]              wait_q, wait_d;
  logic [9:0]              tout_q, tout_d;
  logic                    as_prev_q;
  logic                    romen_q, romen_d, mfpen_q, mfpen_d, ramen_q, ramen_d;
  logic                    dtack_q, dtack_d, berr_q, berr_d;
  logic                    cs_live;
  logic                    unused_addr;

  mack_boot_overlay #(
    .BOOT_CYCLES(BOOT_CYCLES)
  ) u_boot (
    .CLK (CLK),
    .RST (RST),
    .AS  (AS),
    .BOOT(BOOT)
  );

  assign div_d       = div_q + CLK_DIV_LOG2'(1);
  assign CLK_SLOW    = div_q[CLK_DIV_LOG2-1];
  assign unused_addr = ^{ADDR[8:7], ADDR[3:0]};

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
    tout_d   = tout_q;
    case (state_q)
      ST_IDLE: begin
        // as_prev_q requires a high sample first, so a cycle never starts straight out of reset
        if (!AS && as_prev_q) begin
          tout_d = 10'd0;
          wait_d = 4'd0;
          if (!IACK) begin
            region_d = REG_NONE;
            state_d  = ST_EXT;
          end else begin
            region_d = BOOT ? decode_region(ADDR[6:4]) : REG_ROM;
            case (region_d)
              REG_ROM: begin wait_d = ROM_WAIT; state_d = ST_WAIT; end
              REG_RAM: begin wait_d = RAM_WAIT; state_d = ST_WAIT; end
              REG_MFP: state_d = ST_EXT;
              default: state_d = ST_TOUT;
            endcase
          end
        end
      end
      ST_WAIT, ST_EXT, ST_TOUT: begin
        tout_d = tout_q + 10'd1;
        if (AS) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_WAIT) && (wait_q == 4'd0)) begin
          state_d = ST_ACK;
        end else if ((state_q == ST_EXT) && !DTACK_IN) begin
          state_d = ST_ACK;
        end else if (tout_d == TOUT_LAST) begin
          state_d = ST_BERR;
        end
        if ((state_q == ST_WAIT) && (wait_q != 4'd0)) begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: begin
        if (AS) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_comb begin
    cs_live = (state_d == ST_WAIT) || (state_d == ST_EXT) ||
              (state_d == ST_ACK)  || (state_d == ST_BERR);
    romen_d = !(cs_live && (region_d == REG_ROM));
    mfpen_d = !(cs_live && (region_d == REG_MFP));
    ramen_d = !(cs_live && (region_d == REG_RAM));
    dtack_d = (state_d != ST_ACK);
    berr_d  = (state_d != ST_BERR);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      div_q     <= '0;
      state_q   <= ST_IDLE;
      region_q  <= REG_NONE;
      wait_q    <= 4'd0;
      tout_q    <= 10'd0;
      as_prev_q <= 1'b0;
      romen_q   <= 1'b1;
      mfpen_q   <= 1'b1;
      ramen_q   <= 1'b1;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      region_q  <= region_d;
      wait_q    <= wait_d;
      tout_q    <= tout_d;
      as_prev_q <= AS;
      romen_q   <= romen_d;
      mfpen_q   <= mfpen_d;
      ramen_q   <= ramen_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
    end
  end

  assign ROMEN = romen_q;
  assign MFPEN = mfpen_q;
  assign RAMEN = ramen_q;
  assign DTACK = dtack_q;
  assign BERR  = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_mack_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for mack_bus_ctrl: directed scenarios plus randomized bus
// cycles checked every clock against a cycle-level model of the bus rules.
module tb_mack_bus_ctrl;

  localparam int BOOT_CYCLES  = 8;
  localparam int ROM_WS       = 2;
  localparam int RAM_WS       = 0;
  localparam int BERR_TIMEOUT = 64;
  localparam int CLK_DIV_LOG2 = 2;
  localparam int NEVER        = 1 << 30;

  typedef enum {R_NONE, R_ROM, R_MFP, R_RAM, R_IACK} kind_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [8:0] ADDR = 9'd0;
  logic       AS = 1'b1;
  logic       IACK = 1'b1;
  logic       DTACK_IN = 1'b1;
  logic       CLK_SLOW, ROMEN, MFPEN, RAMEN, DTACK, BERR, BOOT;
  logic [6:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  bit boot_m   = 1'b0;
  int boot_cnt = 0;

  mack_bus_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .ROM_WS      (ROM_WS),
    .RAM_WS      (RAM_WS),
    .BERR_TIMEOUT(BERR_TIMEOUT),
    .CLK_DIV_LOG2(CLK_DIV_LOG2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ADDR    (ADDR),
    .AS      (AS),
    .IACK    (IACK),
    .DTACK_IN(DTACK_IN),
    .CLK_SLOW(CLK_SLOW),
    .ROMEN   (ROMEN),
    .MFPEN   (MFPEN),
    .RAMEN   (RAMEN),
    .DTACK   (DTACK),
    .BERR    (BERR),
    .BOOT    (BOOT)
  );

  always #5 CLK = ~CLK;

  assign obs = {CLK_SLOW, ROMEN, MFPEN, RAMEN, DTACK, BERR, BOOT};

  // Clock edges since the last reset edge; the slow clock is bit LOG2-1 of it.
  always @(posedge CLK) edge_n <= RST ? edge_n + 1 : 0;

  function automatic logic slow_ref();
    int t;
    t = edge_n >> (CLK_DIV_LOG2 - 1);
    return t[0];
  endfunction

  // One full AS cycle: AS low for `hold` samples, DTACK_IN first seen low at
  // sample j after the start, then AS high and `gap` further idle clocks.
  task automatic run_cycle(input string tag, input logic [8:0] addr, input logic iack,
                           input int hold, input int j, input int gap);
    kind_t      r;
    int         ack_k;
    int         berr_k;
    bit         acked, bus_err;
    logic [6:0] exp;
    ADDR = addr;
    IACK = iack;
    AS = 1'b0;
    DTACK_IN = 1'b1;
    if (!iack) r = R_IACK;
    else if (!boot_m) r = R_ROM;
    else if (addr[6:4] == 3'd7) r = R_ROM;
    else if (addr[6:4] == 3'd6) r = R_MFP;
    else if (addr[6:4] == 3'd0) r = R_RAM;
    else r = R_NONE;
    if (!boot_m && boot_cnt < 255) boot_cnt++;
    case (r)
      R_ROM:          ack_k = ROM_WS + 1;
      R_RAM:          ack_k = RAM_WS + 1;
      R_MFP, R_IACK:  ack_k = j;
      default:        ack_k = NEVER;
    endcase
    berr_k = BERR_TIMEOUT - 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      acked   = (ack_k <= berr_k) && (k >= ack_k);
      bus_err = (ack_k > berr_k) && (k >= berr_k);
      exp = {slow_ref(), r != R_ROM, r != R_MFP, r != R_RAM, !acked, !bus_err, boot_m};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s k=%0d: got {slow,rom,mfp,ram,dtack,berr,boot}=%b expected %b",
                 tag, k, obs, exp);
      end
      DTACK_IN = (k + 1 >= j) ? 1'b0 : 1'b1;
      if (k == hold - 1) begin
        AS = 1'b1;
        DTACK_IN = 1'b1;
      end
    end
    for (int g = 0; g <= gap; g++) begin
      @(posedge CLK);
      if (!boot_m && boot_cnt >= BOOT_CYCLES) boot_m = 1'b1;
      @(negedge CLK);
      exp = {slow_ref(), 5'b11111, boot_m};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s end+%0d: got %b expected %b", tag, g, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    AS = 1'b1;
    IACK = 1'b1;
    DTACK_IN = 1'b1;
    ADDR = 9'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (obs !== 7'b0111110) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 7'b0111110);
    end
    RST = 1'b1;
    boot_m = 1'b0;
    boot_cnt = 0;
  endtask

  task automatic test_clk_div();
    logic [6:0] exp;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      exp = {slow_ref(), 5'b11111, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL clk_div i=%0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_boot_overlay();
    for (int c = 0; c < BOOT_CYCLES; c++) run_cycle("boot_rom", 9'h000, 1'b1, 4, 2, 0);
    n_checks++;
    if (BOOT !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_set: got BOOT=%b expected 1", BOOT);
    end
    run_cycle("boot_ram", 9'h000, 1'b1, 3, 1, 1);
  endtask

  task automatic test_rom();
    run_cycle("rom_ws", 9'h070, 1'b1, 6, 1, 1);
  endtask

  task automatic test_mfp();
    run_cycle("mfp_ext", 9'h060, 1'b1, 14, 11, 1);
  endtask

  task automatic test_unmapped();
    run_cycle("unmapped", 9'h020, 1'b1, BERR_TIMEOUT + 2, 1, 1);
  endtask

  task automatic test_iack();
    run_cycle("iack_ack", 9'h070, 1'b0, 6, 3, 0);
    run_cycle("iack_tout", 9'h1FF, 1'b0, BERR_TIMEOUT + 2, NEVER, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int hold;
      hold = ($urandom_range(0, 7) == 0) ? BERR_TIMEOUT + 1 : $urandom_range(1, 8);
      run_cycle("random", 9'($urandom), ($urandom_range(0, 5) != 0), hold,
                $urandom_range(1, 12), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    ADDR = 9'h070;
    IACK = 1'b1;
    AS = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    n_checks++;
    if (ROMEN !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rom_select: got ROMEN=%b expected 0", ROMEN);
    end
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (obs !== 7'b0111110) begin
      n_fail++;
      $display("FAIL mid_reset: got %b expected %b", obs, 7'b0111110);
    end
    RST = 1'b1;
    boot_m = 1'b0;
    boot_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      exp = {slow_ref(), 5'b11111, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL held_as_no_start i=%0d: got %b expected %b", i, obs, exp);
      end
    end
    AS = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    run_cycle("post_reset_iack", 9'h020, 1'b0, 3, 2, 0);
    for (int c = 1; c < BOOT_CYCLES; c++) run_cycle("post_reset_rom", 9'h000, 1'b1, 2, 1, 0);
    n_checks++;
    if (BOOT !== 1'b1) begin
      n_fail++;
      $display("FAIL iack_counted_boot: got BOOT=%b expected 1", BOOT);
    end
    run_cycle("post_reset_ram", 9'h000, 1'b1, 3, 1, 1);
  endtask

  initial begin
    test_reset();
    test_clk_div();
    test_boot_overlay();
    test_rom();
    test_mfp();
    test_unmapped();
    test_iack();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
